// File: rtl/histogram_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : histogram_frame_scheduler_pkg
// Brief    : Shared state encodings, default widths and helpers for the
//            histogram frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package histogram_frame_scheduler_pkg;

  localparam int c_frame_id_w = 16;
  localparam int c_drop_cnt_w = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FSIN = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_ARMED     = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_READOUT   = 3'd5
  } sched_state_t;

  // A frame is "in flight" from the clear phase until readout completes.
  function automatic logic is_busy_state(input sched_state_t s);
    return (s != ST_IDLE) && (s != ST_WAIT_FSIN);
  endfunction

  function automatic logic is_acc_state(input sched_state_t s);
    return (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_frame_scheduler_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Brief    : Two-flop synchronizer for an asynchronous strobe followed by a
//            registered one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  // Pulse is registered so the async edge reaches rise_pulse after three edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign rise_pulse = r_rise;

endmodule
`default_nettype wire

// File: rtl/histogram_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : histogram_frame_scheduler
// Brief    : Frame-level sequencer: fsin sync, camera start, bin clear,
//            accumulate gating, readout hand-off and drop/timeout tracking.
// Revision : 1.0 - initial release
// ============================================================================
module histogram_frame_scheduler
  import histogram_frame_scheduler_pkg::*;
#(
  parameter int CLEAR_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FRAME_ID_W     = c_frame_id_w,
  parameter int DROP_CNT_W     = c_drop_cnt_w
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  fsin,
  input  logic                  frame_valid,
  input  logic                  line_valid,
  input  logic                  readout_done,
  input  logic                  clr_err,
  output logic                  cam_en,
  output logic                  hist_clear,
  output logic                  hist_acc_en,
  output logic                  readout_start,
  output logic [FRAME_ID_W-1:0] frame_id,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  err_timeout,
  output logic                  err_overlap,
  output logic                  busy
);

  localparam int c_clr_w = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_clr_w-1:0] c_clr_load = c_clr_w'(CLEAR_CYCLES - 1);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);

  sched_state_t          r_state;
  sched_state_t          w_next_state;
  logic [c_clr_w-1:0]    r_clr_cnt;
  logic [c_to_w-1:0]     r_to_cnt;
  logic                  r_fv_d;
  logic                  r_cam_en;
  logic                  r_hist_clear;
  logic                  r_readout_start;
  logic                  r_busy;
  logic [FRAME_ID_W-1:0] r_frame_id;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  r_err_timeout;
  logic                  r_err_overlap;

  logic                  w_fsin_rise;
  logic                  w_fv_rise;
  logic                  w_start;
  logic                  w_overlap;
  logic                  w_timeout;
  logic                  w_frame_done;
  logic                  w_fsin_drop;
  logic [1:0]            w_drop_inc;
  logic [DROP_CNT_W-1:0] w_drop_base;
  logic [DROP_CNT_W:0]   w_drop_sum;
  logic [DROP_CNT_W-1:0] w_drop_next;

  sync_edge_detect u_fsin_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (fsin),
    .rise_pulse (w_fsin_rise)
  );

  assign w_fv_rise = frame_valid & ~r_fv_d;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_overlap    = 1'b0;
    w_timeout    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next_state = ST_WAIT_FSIN;
      end
      ST_WAIT_FSIN: begin
        if (!run) begin
          w_next_state = ST_IDLE;
        end else if (w_fsin_rise) begin
          w_start      = 1'b1;
          w_next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // A frame starting before the bins are clean is abandoned outright.
        if (w_fv_rise) begin
          w_overlap    = 1'b1;
          w_next_state = ST_WAIT_FSIN;
        end else if (r_clr_cnt == '0) begin
          w_next_state = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (frame_valid) begin
          w_next_state = ST_CAPTURE;
        end else if (r_to_cnt == c_to_last) begin
          w_timeout    = 1'b1;
          w_next_state = ST_WAIT_FSIN;
        end
      end
      ST_CAPTURE: begin
        if (!frame_valid) begin
          w_frame_done = 1'b1;
          w_next_state = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (readout_done) w_next_state = run ? ST_WAIT_FSIN : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Syncs landing while a frame is in flight are counted, never serviced.
  assign w_fsin_drop = w_fsin_rise & is_busy_state(r_state);
  assign w_drop_inc  = {1'b0, w_overlap} + {1'b0, w_fsin_drop};
  assign w_drop_base = clr_err ? '0 : r_drop_cnt;
  assign w_drop_sum  = {1'b0, w_drop_base} + {{(DROP_CNT_W-1){1'b0}}, w_drop_inc};
  assign w_drop_next = w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_clr_cnt       <= '0;
      r_to_cnt        <= '0;
      r_fv_d          <= 1'b0;
      r_cam_en        <= 1'b0;
      r_hist_clear    <= 1'b0;
      r_readout_start <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_id      <= '0;
      r_drop_cnt      <= '0;
      r_err_timeout   <= 1'b0;
      r_err_overlap   <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_fv_d          <= frame_valid;
      r_cam_en        <= w_start;
      r_hist_clear    <= (w_next_state == ST_CLEAR);
      r_readout_start <= w_frame_done;
      r_busy          <= is_busy_state(w_next_state);
      r_drop_cnt      <= w_drop_next;

      if (w_start) begin
        r_clr_cnt <= c_clr_load;
      end else if ((r_state == ST_CLEAR) && (r_clr_cnt != '0)) begin
        r_clr_cnt <= r_clr_cnt - 1'b1;
      end

      if (r_state == ST_ARMED) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      if (w_frame_done) r_frame_id <= r_frame_id + 1'b1;

      // New errors take priority over a same-cycle clear request.
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end else if (clr_err) begin
        r_err_timeout <= 1'b0;
      end

      if (w_overlap) begin
        r_err_overlap <= 1'b1;
      end else if (clr_err) begin
        r_err_overlap <= 1'b0;
      end
    end
  end

  assign hist_acc_en   = is_acc_state(r_state) & frame_valid & line_valid;
  assign cam_en        = r_cam_en;
  assign hist_clear    = r_hist_clear;
  assign readout_start = r_readout_start;
  assign busy          = r_busy;
  assign frame_id      = r_frame_id;
  assign drop_cnt      = r_drop_cnt;
  assign err_timeout   = r_err_timeout;
  assign err_overlap   = r_err_overlap;

endmodule
`default_nettype wire
